fir_axilite_slave: RTL and testbench

AXI-Lite responder that terminates the configuration channel of the FIR accelerator: the wishbone-to-AXI-Lite bridge issues aw/w/ar transactions, and this block completes them. It holds the ap_ctrl and data_length registers and routes coefficient accesses to the tap BRAM. While the FIR core is running, it hands the tap BRAM to the core.

---
 rtl/fir_axilite_slave.sv | 182 ++++++++++++++++++
 tb/tb_fir_axilite_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axilite_slave.sv
// AXI-Lite configuration responder for the FIR accelerator: ap_ctrl, data_length, tap BRAM.
// Optional: define FIR_AXIL_TAP_READBACK_EN to let tap-window reads return BRAM contents.
module fir_axilite_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TAP_NUM    = 11
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ap_start,
    input  logic                  core_done,
    output logic [DATA_WIDTH-1:0] data_length,
    input  logic                  core_busy,
    input  logic                  core_tap_EN,
    input  logic [ADDR_WIDTH-1:0] core_tap_A,
    output logic                  tap_EN,
    output logic [3:0]            tap_WE,
    output logic [ADDR_WIDTH-1:0] tap_A,
    output logic [DATA_WIDTH-1:0] tap_Di,
    input  logic [DATA_WIDTH-1:0] tap_Do
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LEN  = ADDR_WIDTH'(16);
    localparam logic [ADDR_WIDTH-1:0] TAP_BASE  = ADDR_WIDTH'(64);
    localparam logic [ADDR_WIDTH-1:0] TAP_END   = ADDR_WIDTH'(64 + 4 * TAP_NUM);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RD_RESP} state_t;

    state_t                  state;
    logic                    ap_idle;
    logic                    ap_done;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    rd_busy_q;
    logic                    tap_en_q;
    logic [3:0]              tap_we_q;
    logic [ADDR_WIDTH-1:0]   tap_a_q;
    logic [DATA_WIDTH-1:0]   tap_di_q;
    logic [DATA_WIDTH-1:0]   tap_rd;
    logic [DATA_WIDTH-1:0]   ctrl_word;
    logic [DATA_WIDTH-1:0]   rd_value;
    logic                    wr_fire;
    logic                    ctrl_rd_hs;

    function automatic logic in_tap(input logic [ADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END);
    endfunction

`ifdef FIR_AXIL_TAP_READBACK_EN
    assign tap_rd = tap_Do;
`else
    logic unused_tap_do;
    assign unused_tap_do = ^tap_Do;
    assign tap_rd        = '0;
`endif

    assign ctrl_word  = {{(DATA_WIDTH-3){1'b0}}, ap_idle, ap_done, ap_start};
    assign wr_fire    = (state == IDLE) && awvalid && wvalid;
    assign ctrl_rd_hs = (state == RD_RESP) && rready && (rd_addr_q == ADDR_CTRL);

    always_comb begin
        rd_value = '0;
        if (in_tap(rd_addr_q))
            rd_value = rd_busy_q ? '1 : tap_rd;
        else if (rd_addr_q == ADDR_CTRL)
            rd_value = ctrl_word;
        else if (rd_addr_q == ADDR_LEN)
            rd_value = data_length;
    end

    // Core owns the BRAM port while busy; the bus side is muted.
    assign tap_EN = core_busy ? core_tap_EN : tap_en_q;
    assign tap_WE = core_busy ? 4'h0 : tap_we_q;
    assign tap_A  = core_busy ? core_tap_A : tap_a_q;
    assign tap_Di = tap_di_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rd_addr_q <= '0;
            rd_busy_q <= 1'b0;
            tap_en_q  <= 1'b0;
            tap_we_q  <= 4'h0;
            tap_a_q   <= '0;
            tap_di_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (awvalid && wvalid) begin
                        state   <= WR;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        if (in_tap(awaddr) && !core_busy) begin
                            tap_en_q <= 1'b1;
                            tap_we_q <= 4'hF;
                            tap_a_q  <= awaddr - TAP_BASE;
                            tap_di_q <= wdata;
                        end
                    end else if (arvalid) begin
                        state     <= RD_ADDR;
                        arready   <= 1'b1;
                        rd_addr_q <= araddr;
                        rd_busy_q <= core_busy;
`ifdef FIR_AXIL_TAP_READBACK_EN
                        if (in_tap(araddr) && !core_busy) begin
                            tap_en_q <= 1'b1;
                            tap_we_q <= 4'h0;
                            tap_a_q  <= araddr - TAP_BASE;
                        end
`endif
                    end
                end
                WR: begin
                    awready  <= 1'b0;
                    wready   <= 1'b0;
                    tap_en_q <= 1'b0;
                    tap_we_q <= 4'h0;
                    state    <= IDLE;
                end
                RD_ADDR: begin
                    arready  <= 1'b0;
                    tap_en_q <= 1'b0;
                    state    <= RD_DATA;
                end
                RD_DATA: begin
                    rdata  <= rd_value;
                    rvalid <= 1'b1;
                    state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start    <= 1'b0;
            ap_idle     <= 1'b1;
            ap_done     <= 1'b0;
            data_length <= '0;
        end else begin
            ap_start <= 1'b0;
            if (wr_fire && awaddr == ADDR_CTRL && wdata[0] && ap_idle) begin
                ap_start <= 1'b1;
                ap_idle  <= 1'b0;
            end
            if (wr_fire && awaddr == ADDR_LEN && ap_idle)
                data_length <= wdata;
            if (ctrl_rd_hs)
                ap_done <= 1'b0;
            // Completion is applied last so it beats a same-cycle read clear.
            if (core_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_axilite_slave.sv
// Scoreboard bench for fir_axilite_slave with a behavioural tap BRAM.
module tb_fir_axilite_slave;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        ap_start, core_done = 1'b0, core_busy = 1'b0, core_tap_EN = 1'b0;
    logic [31:0] data_length;
    logic [11:0] core_tap_A = '0;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
    logic [31:0] tap_Di;
    logic [31:0] tap_Do = '0;

    fir_axilite_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TAP_NUM(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ap_start(ap_start), .core_done(core_done), .data_length(data_length),
        .core_busy(core_busy), .core_tap_EN(core_tap_EN), .core_tap_A(core_tap_A),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di),
        .tap_Do(tap_Do)
    );

    always #5 axis_clk = ~axis_clk;

    logic [31:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {logic [31:0] data; string name;} rexp_t;
    typedef struct {logic en; logic [3:0] we; bit chk_a; logic [11:0] a; logic [31:0] di;} wexp_t;
    rexp_t rq[$];
    wexp_t wq[$];
    rexp_t re;
    wexp_t wx;
    int start_cnt = 0, start_run = 0, max_run = 0;

    always @(negedge axis_clk) begin
        if (axis_rst_n) begin
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got %0h expected none", rdata);
                end else begin
                    re = rq.pop_front();
                    chk(re.name, rdata, re.data);
                end
            end
            if (awready) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got handshake expected none");
                end else begin
                    wx = wq.pop_front();
                    chk("wr_wready", {31'b0, wready}, 32'd1);
                    chk("wr_tap_EN", {31'b0, tap_EN}, {31'b0, wx.en});
                    chk("wr_tap_WE", {28'b0, tap_WE}, {28'b0, wx.we});
                    if (wx.chk_a) chk("wr_tap_A", {20'b0, tap_A}, {20'b0, wx.a});
                    if (wx.we == 4'hF) chk("wr_tap_Di", tap_Di, wx.di);
                end
            end
        end
        if (ap_start) begin
            start_cnt++;
            start_run++;
            if (start_run > max_run) max_run = start_run;
        end else start_run = 0;
    end

    task automatic wait_sig(input int sel, input string what);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            if ((sel == 0 && awready) || (sel == 1 && arready) || (sel == 2 && rvalid)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got no handshake expected one within 20 cycles", what);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input wexp_t e);
        wq.push_back(e);
        @(posedge axis_clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        wait_sig(0, "awready");
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input int stall,
                            input string name);
        rq.push_back('{exp, name});
        @(posedge axis_clk); #1;
        araddr = a; arvalid = 1'b1;
        wait_sig(1, "arready");
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        if (stall == 0) rready = 1'b1;
        wait_sig(2, "rvalid");
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge axis_clk); #1;
                @(negedge axis_clk);
                chk("rvalid_hold", {31'b0, rvalid}, 32'd1);
                chk("rdata_hold", rdata, exp);
            end
            @(posedge axis_clk); #1;
            rready = 1'b1;
            @(negedge axis_clk);
        end
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    localparam wexp_t W_REG = '{1'b0, 4'h0, 1'b0, 12'h0, 32'h0};
    logic [31:0] exp_tap5, exp_tap33;
    int s0, n;

    initial begin
`ifdef FIR_AXIL_TAP_READBACK_EN
        exp_tap5 = 32'h5; exp_tap33 = 32'h33;
`else
        exp_tap5 = 32'h0; exp_tap33 = 32'h0;
`endif
        repeat (2) @(posedge axis_clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 0);
        chk("rst_wready", {31'b0, wready}, 0);
        chk("rst_arready", {31'b0, arready}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_ap_start", {31'b0, ap_start}, 0);
        chk("rst_tap_EN", {31'b0, tap_EN}, 0);
        chk("rst_tap_WE", {28'b0, tap_WE}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_data_length", data_length, 0);
        chk("rst_tap_A", {20'b0, tap_A}, 0);
        chk("rst_tap_Di", tap_Di, 0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;

        axi_write(12'h040, 32'h5, '{1'b1, 4'hF, 1'b1, 12'h000, 32'h5});
        @(negedge axis_clk);
        chk("tap_EN_one_cycle", {31'b0, tap_EN}, 0);
        axi_read(12'h040, exp_tap5, 0, "rd_tap0");

        axi_write(12'h010, 32'd64, W_REG);
        axi_read(12'h010, 32'd64, 3, "rd_len64");
        chk("data_length_64", data_length, 32'd64);

        s0 = start_cnt;
        axi_write(12'h000, 32'h1, W_REG);
        repeat (3) @(posedge axis_clk);
        #1;
        chk("ap_start_pulses", start_cnt - s0, 1);
        axi_read(12'h000, 32'h0, 0, "rd_ctrl_running");
        axi_write(12'h010, 32'd99, W_REG);
        axi_read(12'h010, 32'd64, 0, "rd_len_locked");
        s0 = start_cnt;
        axi_write(12'h000, 32'h1, W_REG);
        repeat (3) @(posedge axis_clk);
        #1;
        chk("ap_start_ignored", start_cnt - s0, 0);
        @(posedge axis_clk); #1;
        core_done = 1'b1;
        @(posedge axis_clk); #1;
        core_done = 1'b0;
        axi_read(12'h000, 32'h6, 0, "rd_ctrl_done");
        axi_read(12'h000, 32'h4, 0, "rd_ctrl_cleared");

        axi_write(12'h020, 32'hAB, W_REG);
        axi_read(12'h020, 32'h0, 0, "rd_unmapped");
        axi_read(12'h06C, 32'h0, 0, "rd_past_taps");

        // Write and read offered together: write goes first
        wq.push_back(W_REG);
        rq.push_back('{32'd7, "rd_after_simul_wr"});
        @(posedge axis_clk); #1;
        awaddr = 12'h010; wdata = 32'd7; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h010; arvalid = 1'b1;
        wait_sig(0, "simul_awready");
        chk("simul_no_arready", {31'b0, arready}, 0);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            n++;
            if (arready) break;
        end
        chk("simul_ar_gap_ok", {31'b0, (n >= 2 && n < 20)}, 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        wait_sig(2, "simul_rvalid");
        @(posedge axis_clk); #1;
        rready = 1'b0;

        axi_write(12'h044, 32'h33, '{1'b1, 4'hF, 1'b1, 12'h004, 32'h33});
        @(posedge axis_clk); #1;
        core_busy = 1'b1; core_tap_EN = 1'b1; core_tap_A = 12'h028;
        #1;
        chk("busy_tap_A", {20'b0, tap_A}, 32'h028);
        chk("busy_tap_EN", {31'b0, tap_EN}, 1);
        axi_write(12'h044, 32'h9, '{1'b1, 4'h0, 1'b1, 12'h028, 32'h0});
        axi_read(12'h044, 32'hFFFF_FFFF, 0, "rd_tap_busy");
        core_tap_A = 12'h01C;
        #1;
        chk("busy_tap_A_track", {20'b0, tap_A}, 32'h01C);
        @(posedge axis_clk); #1;
        core_busy = 1'b0; core_tap_EN = 1'b0;
        axi_read(12'h044, exp_tap33, 0, "rd_tap1_kept");

        @(posedge axis_clk); #1;
        araddr = 12'h010; arvalid = 1'b1;
        wait_sig(1, "rst_arready");
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        wait_sig(2, "rst_rvalid");
        #2;
        axis_rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'b0, rvalid}, 0);
        chk("rst_mid_len", data_length, 0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        axi_read(12'h000, 32'h4, 0, "rd_ctrl_after_rst");
        axi_read(12'h010, 32'h0, 0, "rd_len_after_rst");

        repeat (2) @(posedge axis_clk);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("ap_start_max_width", max_run, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
